// File: rtl/aes_block_loader_pkg.sv
// Shared AES definitions for the block loader: byte/word/state types,
// group geometry and the beat-kind encoding.
package aes_block_loader_pkg;

    typedef logic [7:0]  byte_t;
    typedef logic [31:0] word_t;

    // state[j][k]: column j, byte k; [0][0] is the most significant byte.
    typedef byte_t [0:3][0:3] state_t;

    localparam int BEATS_PER_BLOCK = 4;
    localparam logic [1:0] LAST_BEAT = 2'(BEATS_PER_BLOCK - 1);

    // Kind of a 4-beat group, latched from its first beat.
    typedef enum logic {
        KIND_DATA = 1'b0,
        KIND_KEY  = 1'b1
    } kind_e;

    // Collector FSM states.
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } col_state_e;

endpackage

// File: rtl/aes_word_collector.sv
// Word collector: packs four accepted 32-bit beats into one state_t,
// latches the group kind from the first beat and flags kind mismatches.
// done/mismatch are combinational with the accepted beat so the parent
// can commit on the same edge that takes the last beat.
module aes_word_collector
    import aes_block_loader_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       beatValid,
    input  logic       beatIsKey,
    input  word_t      beatData,
    output logic [1:0] cnt,
    output kind_e      kind,
    output logic       done,
    output kind_e      doneKind,
    output state_t     doneState,
    output logic       mismatch
);

    col_state_e colState, nextState;
    logic [1:0] nextCnt;
    kind_e      nextKind;
    kind_e      beatKind;
    state_t     colBuf;
    logic       storeBeat;

    assign beatKind = kind_e'(beatIsKey);

    // State register for the collector FSM, beat counter and latched kind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            colState <= ST_IDLE;
            cnt      <= '0;
            kind     <= KIND_DATA;
        end else begin
            // NOTE: state flops use non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            colState <= nextState;
            cnt      <= nextCnt;
            kind     <= nextKind;
        end
    end

    // Next-state logic: count beats, detect mismatch, flag the last beat.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no
        // path through the case/if tree can leave one unassigned (latch).
        nextState = colState;
        nextCnt   = cnt;
        nextKind  = kind;
        done      = 1'b0;
        mismatch  = 1'b0;
        doneKind  = kind;
        doneState = colBuf;
        doneState[3] = beatData;
        if (flush) begin
            nextState = ST_IDLE;
            nextCnt   = '0;
        end else if (beatValid) begin
            case (colState)
                ST_IDLE: begin
                    nextKind  = beatKind;
                    nextCnt   = 2'd1;
                    nextState = ST_COLLECT;
                end
                ST_COLLECT: begin
                    if (beatKind != kind) begin
                        mismatch  = 1'b1;
                        nextCnt   = '0;
                        nextState = ST_IDLE;
                    end else if (cnt == LAST_BEAT) begin
                        done      = 1'b1;
                        nextCnt   = '0;
                        nextState = ST_IDLE;
                    end else begin
                        nextCnt = cnt + 2'd1;
                    end
                end
                default: begin
                    nextCnt   = '0;
                    nextState = ST_IDLE;
                end
            endcase
        end
    end

    // Columns 0..2 are buffered; column 3 is taken straight from the bus.
    assign storeBeat = beatValid && !flush && !mismatch && !done;

    // Column store: beat j lands in column j.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the column buffer is a dozen bytes of flops, not a RAM,
            // so it takes the reset like every other register here.
            colBuf <= '0;
        end else if (storeBeat) begin
            colBuf[cnt] <= beatData;
        end
    end

endmodule

// File: rtl/aes_block_loader.sv
// AES block loader: turns a 32-bit valid/ready beat stream into a held
// {plaintext, key} pair for the combinational AES-128 cipher.
// Optional macro AES_BLOCK_LOADER_ERR_CNT_EN adds a saturating err_cnt port.
module aes_block_loader
    import aes_block_loader_pkg::*;
#(
    parameter int BEATS_PER_BLOCK = 4,
    parameter int ERR_CNT_W       = 8
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    input  logic   in_valid,
    output logic   in_ready,
    input  word_t  in_data,
    input  logic   in_is_key,
    output logic   out_valid,
    input  logic   out_ready,
    output state_t out_data,
    output state_t out_key,
    output logic   key_loaded,
    output logic   err
`ifdef AES_BLOCK_LOADER_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    if (BEATS_PER_BLOCK != 4 || ERR_CNT_W < 1) begin : gBadConfig
        $error("aes_block_loader: BEATS_PER_BLOCK must be 4 and ERR_CNT_W >= 1");
    end

    logic [1:0] cnt;
    kind_e      kind;
    logic       done;
    kind_e      doneKind;
    state_t     doneState;
    logic       mismatch;
    logic       beatAccept;
    logic       dataCommit;
    logic       keyCommit;
    logic       errNow;
    state_t     keyReg;

    // Stall only the last data beat while an undrained block is held.
    assign in_ready = !(cnt == LAST_BEAT && kind == KIND_DATA && out_valid && !out_ready);
    assign beatAccept = in_valid && in_ready;

    aes_word_collector colInst (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .beatValid (beatAccept),
        .beatIsKey (in_is_key),
        .beatData  (in_data),
        .cnt       (cnt),
        .kind      (kind),
        .done      (done),
        .doneKind  (doneKind),
        .doneState (doneState),
        .mismatch  (mismatch)
    );

    assign keyCommit  = done && doneKind == KIND_KEY;
    assign dataCommit = done && doneKind == KIND_DATA && key_loaded;
    assign errNow     = mismatch || (done && doneKind == KIND_DATA && !key_loaded);

    // Key register: replaced on a key commit; flush leaves it alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            keyReg     <= '0;
            key_loaded <= 1'b0;
        end else if (keyCommit) begin
            keyReg     <= doneState;
            key_loaded <= 1'b1;
        end
    end

    // Output register and handshake; a data commit snapshots the pre-edge key.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_key   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_key   <= '0;
        end else if (dataCommit) begin
            out_valid <= 1'b1;
            out_data  <= doneState;
            out_key   <= keyReg;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // One-cycle error pulse for a discarded group.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else begin
            err <= errNow;
        end
    end

`ifdef AES_BLOCK_LOADER_ERR_CNT_EN
    // Saturating count of error pulses, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt <= '0;
        end else if (errNow && err_cnt != '1) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed testbench for aes_block_loader with hand-computed vectors.
module tb_aes_block_loader;
    import aes_block_loader_pkg::*;

    localparam logic [127:0] KEY_A  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] KEY_B  = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    localparam logic [127:0] DATA_A = 128'h3243f6a8_885a308d_313198a2_e0370734;
    localparam logic [127:0] DATA_B = 128'h00112233_44556677_8899aabb_ccddeeff;

    logic   clk = 1'b0;
    logic   rst;
    logic   flush;
    logic   in_valid;
    logic   in_ready;
    word_t  in_data;
    logic   in_is_key;
    logic   out_valid;
    logic   out_ready;
    state_t out_data;
    state_t out_key;
    logic   key_loaded;
    logic   err;
`ifdef AES_BLOCK_LOADER_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int numChecks = 0;
    int numFails  = 0;

    always #5 clk = ~clk;

    aes_block_loader dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_is_key  (in_is_key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_key    (out_key),
        .key_loaded (key_loaded),
        .err        (err)
`ifdef AES_BLOCK_LOADER_ERR_CNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        numChecks++;
        if (got !== exp) begin
            numFails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one beat until accepted; returns 1 time unit after the accepting edge.
    task automatic sendBeat(input word_t w, input logic isKey);
        in_valid  = 1'b1;
        in_data   = w;
        in_is_key = isKey;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        check("beat_accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic sendBeats(input logic [127:0] blk, input logic isKey, input int n);
        for (int j = 0; j < n; j++) sendBeat(blk[127 - 32*j -: 32], isKey);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        in_is_key = 1'b0; out_ready = 1'b1;
        #2;
        check("rst_in_ready",   in_ready,   1'b1);
        check("rst_out_valid",  out_valid,  1'b0);
        check("rst_out_data",   out_data,   128'h0);
        check("rst_out_key",    out_key,    128'h0);
        check("rst_key_loaded", key_loaded, 1'b0);
        check("rst_err",        err,        1'b0);
        tick();
        rst = 1'b1;
        tick();

        // Data group with no key loaded: error, no output.
        sendBeats(DATA_A, 1'b0, 4);
        check("nokey_err",       err,       1'b1);
        check("nokey_out_valid", out_valid, 1'b0);
`ifdef AES_BLOCK_LOADER_ERR_CNT_EN
        check("nokey_err_cnt", err_cnt, 8'd1);
`endif
        tick();
        check("nokey_err_falls", err, 1'b0);

        // FIPS-197 key then plaintext.
        sendBeats(KEY_A, 1'b1, 4);
        check("key_loaded", key_loaded, 1'b1);
        sendBeats(DATA_A, 1'b0, 3);
        check("pre_commit_out_valid", out_valid, 1'b0);
        sendBeat(DATA_A[31:0], 1'b0);
        check("commit_out_valid", out_valid,      1'b1);
        check("commit_col0",      out_data[0],    32'h3243f6a8);
        check("commit_byte00",    out_data[0][0], 8'h32);
        check("commit_key_col3",  out_key[3],     32'h09cf4f3c);
        check("commit_data",      out_data,       DATA_A);
        check("commit_key",       out_key,        KEY_A);
        check("commit_err",       err,            1'b0);
        tick();
        check("drain_out_valid", out_valid, 1'b0);

        // Mismatch at cnt=2 (key,key,data), then at cnt=3 (data x3, key).
        sendBeats(KEY_B, 1'b1, 2);
        sendBeat(32'hdeadbeef, 1'b0);
        check("mm2_err", err, 1'b1);
        sendBeats(DATA_B, 1'b0, 3);
        sendBeat(32'hcafef00d, 1'b1);
        check("mm3_err",       err,       1'b1);
        check("mm3_out_valid", out_valid, 1'b0);
        check("mm_key_kept",   out_key,   KEY_A);
`ifdef AES_BLOCK_LOADER_ERR_CNT_EN
        check("mm_err_cnt", err_cnt, 8'd3);
`endif
        sendBeats(DATA_B, 1'b0, 4);
        check("clean_out_valid", out_valid, 1'b1);
        check("clean_out_data",  out_data,  DATA_B);
        check("clean_out_key",   out_key,   KEY_A);
        tick();
        check("clean_drain", out_valid, 1'b0);

        // Backpressure: second group's last beat stalls until drain.
        out_ready = 1'b0;
        sendBeats(DATA_A, 1'b0, 4);
        check("bp_first_valid", out_valid, 1'b1);
        check("bp_ready_cnt0",  in_ready,  1'b1);
        sendBeats(DATA_B, 1'b0, 3);
        check("bp_ready_cnt3", in_ready, 1'b0);
        in_valid = 1'b1; in_data = DATA_B[31:0]; in_is_key = 1'b0;
        tick();
        check("bp_still_stalled", in_ready,  1'b0);
        check("bp_held_data",     out_data,  DATA_A);
        check("bp_held_valid",    out_valid, 1'b1);
        out_ready = 1'b1;
        #1;
        check("bp_ready_on_drain", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        check("bp_second_valid", out_valid, 1'b1);
        check("bp_second_data",  out_data,  DATA_B);
        tick();
        check("bp_second_drain", out_valid, 1'b0);

        // New key while a block is held: held snapshot unchanged.
        out_ready = 1'b0;
        sendBeats(DATA_A, 1'b0, 4);
        sendBeats(KEY_B, 1'b1, 4);
        check("snap_held_key",  out_key,   KEY_A);
        check("snap_held_data", out_data,  DATA_A);
        check("snap_valid",     out_valid, 1'b1);
        out_ready = 1'b1;
        tick();
        check("snap_drain", out_valid, 1'b0);
        sendBeats(DATA_B, 1'b0, 4);
        check("snap_new_key",  out_key,  KEY_B);
        check("snap_new_data", out_data, DATA_B);
        tick();

        // flush at cnt=2 with a block held; the beat on the flush cycle is dropped.
        out_ready = 1'b0;
        sendBeats(DATA_A, 1'b0, 4);
        sendBeats(DATA_B, 1'b0, 2);
        flush = 1'b1; in_valid = 1'b1; in_data = 32'h12345678; in_is_key = 1'b0;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid",  out_valid,  1'b0);
        check("flush_out_data",   out_data,   128'h0);
        check("flush_key_loaded", key_loaded, 1'b1);
        check("flush_in_ready",   in_ready,   1'b1);
        sendBeats(DATA_B, 1'b0, 4);
        check("post_flush_valid", out_valid, 1'b1);
        check("post_flush_data",  out_data,  DATA_B);
        check("post_flush_key",   out_key,   KEY_B);

        // Asynchronous reset mid-group.
        out_ready = 1'b1;
        tick();
        sendBeats(DATA_A, 1'b0, 2);
        #2;
        rst = 1'b0;
        #1;
        check("arst_out_valid",  out_valid,  1'b0);
        check("arst_key_loaded", key_loaded, 1'b0);
        check("arst_out_data",   out_data,   128'h0);
        check("arst_out_key",    out_key,    128'h0);
        check("arst_in_ready",   in_ready,   1'b1);
        check("arst_err",        err,        1'b0);
        tick();
        rst = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
